md_sequencer: RTL and testbench
===============================

Name: md_sequencer

Overview:
- Multi-cycle multiply/divide unit with its own sequencer for the pipelined MIPS32 core.
- Owns the HI/LO registers and executes mult/multu/div/divu over a fixed cycle count.
- Executes mthi/mtlo in a single cycle.
- Sits beside the ALU in the E stage. Exposes busy so the hazard logic can stall D-stage MD instructions and mfhi/mflo until the result is committed.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy duration in cycles for div/divu (must be >= 1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  E-stage MD instruction valid this cycle.
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- busy  output  1  multi-cycle operation in flight.
- hi  output  32  current HI register.
- lo  output  32  current LO register.

Behaviour:
- Reset (asynchronous, active-high): busy=0, counter=0, hi=0, lo=0, latched operands/op cleared. Any in-flight result is discarded.
- States: IDLE (busy=0), RUN (busy=1). busy is a registered output. hi and lo are direct register outputs.
- IDLE, start=1, md_op in 1..4:
  - At that clock edge, latch A, B and md_op, load counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4), go to RUN.
  - busy=1 from the next cycle onward.
- RUN, each edge:
  - If counter>1, decrement.
  - If counter==1, write HI/LO from the latched operands, set counter=0, return to IDLE.
  - busy is therefore high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES). New hi/lo are visible in the first cycle busy=0.
- Result computation uses the latched operands only. A/B changes during RUN have no effect.
- mult: {hi,lo} = signed 32x32 -> 64-bit product.
- multu: {hi,lo} = unsigned 32x32 -> 64-bit product.
- div:
  - lo = signed quotient, truncated toward zero; hi = remainder with the sign of the dividend (A).
  - Special case A=0x80000000, B=0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: lo = A/B, hi = A%B, both unsigned.
- Divide by zero (div or divu, B==0): full DIV_CYCLES busy period still runs; hi and lo are left unchanged.
- mthi/mtlo (IDLE, start=1, md_op 5/6): hi<=A or lo<=A at that edge, no busy cycle.
- start with md_op 0 or 7: no effect.
- start=1 while in RUN (any md_op): ignored.
  - The pipeline guarantees this never happens by stalling on busy.
  - An assertion in the bench flags it.
  - The RTL must not corrupt state if it does.
- Completion edge with start=1 in the same cycle: treated as RUN, so start is ignored. The pipeline re-presents the instruction one cycle later, in IDLE.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs zero. No partial write to hi/lo.
- Counter never wraps. It is loaded only in IDLE and stops at 0.

Test Plan:
1. Reset, then start mult with A=0xFFFFFFFE (-2), B=3 -> busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. start multu with A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001. Changing A/B during busy has no effect on the result.
3. start div with A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then divu with A=7, B=0 -> busy for 10 cycles; hi/lo keep their previous values.
4. mthi with A=0x12345678, then mtlo with A=0x9ABCDEF0 on consecutive cycles -> hi/lo update on each edge; busy stays 0.
5. Start divu with A=100, B=7, then at busy cycle 4 pulse start with md_op=5, A=0xDEADBEEF -> pulse ignored; final hi=2, lo=14.
6. Start div, assert reset at busy cycle 3 -> busy, hi and lo all 0 immediately. Then start mult with A=6, B=7 -> lo=42, hi=0 after 5 cycles.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide unit owning HI/LO for the MIPS32 E stage.
// mult/multu/div/divu hold busy for a fixed cycle count and commit HI/LO on completion;
// mthi/mtlo write in a single cycle while idle.
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic               busy_q;
  logic [31:0]        hi_q;
  logic [31:0]        lo_q;

  logic [31:0]        hi_d;
  logic [31:0]        lo_d;
  logic               res_we_d;

  // Arithmetic datapath on latched operands; divisors are forced to 1 when the
  // quotient is unused (B==0) or fixed by the overflow special case.
  logic               div_ovf;
  logic [31:0]        divu_b;
  logic signed [31:0] a_s;
  logic signed [31:0] div_b_s;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;

  assign div_ovf = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
  assign divu_b  = (b_q == 32'd0) ? 32'd1 : b_q;
  assign a_s     = $signed(a_q);
  assign div_b_s = ((b_q == 32'd0) || div_ovf) ? 32'sd1 : $signed(b_q);
  assign quo_s   = a_s / div_b_s;
  assign rem_s   = a_s % div_b_s;
  assign prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u  = {32'd0, a_q} * {32'd0, b_q};

  // Select the HI/LO values committed on the completion edge.
  always_comb begin
    res_we_d = 1'b1;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (op_q)
      OP_MULT:  {hi_d, lo_d} = 64'(prod_s);
      OP_MULTU: {hi_d, lo_d} = prod_u;
      OP_DIV: begin
        if (b_q == 32'd0) begin
          res_we_d = 1'b0;
        end else if (div_ovf) begin
          lo_d = 32'h8000_0000;
          hi_d = 32'd0;
        end else begin
          lo_d = 32'(quo_s);
          hi_d = 32'(rem_s);
        end
      end
      OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_we_d = 1'b0;
        end else begin
          lo_d = a_q / divu_b;
          hi_d = a_q % divu_b;
        end
      end
      default: res_we_d = 1'b0;
    endcase
  end

  // Sequencer: launch in IDLE, count down in RUN, commit HI/LO when the count expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                op_q    <= md_op;
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= CNT_W'(MULT_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                op_q    <= md_op;
                a_q     <= A;
                b_q     <= B;
                cnt_q   <= CNT_W'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          // start is ignored here, including on the completion edge.
          if (cnt_q > CNT_W'(1)) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            if (res_we_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: busy duration, HI/LO results, mthi/mtlo,
// ignored starts while busy, and reset in the middle of an operation.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int illegal_starts = 0;
  int n;

  md_sequencer #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .md_op(md_op),
    .A    (A),
    .B    (B),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline should never present start while busy; tally any occurrence.
  always @(posedge clk) begin
    if (!reset && start && busy) illegal_starts++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one start pulse at the current negedge; returns at the next negedge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
  endtask

  // Count negedges with busy high; stop at the first idle negedge (bounded).
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 64) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    A     = 32'd0;
    B     = 32'd0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: mult -2 * 3
    start_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    check("mult_busy_cycles", 32'(n), 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);

    // 2: multu max*max, operands disturbed while busy
    start_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    A = 32'd3;
    B = 32'd5;
    wait_idle(n);
    check("multu_busy_cycles", 32'(n), 32'd5);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    // 3: div -7 / 2, then divu by zero leaves HI/LO alone
    start_op(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_busy_cycles", 32'(n), 32'd10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    start_op(3'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_busy_cycles", 32'(n), 32'd10);
    check("divu0_lo", lo, 32'hFFFF_FFFD);
    check("divu0_hi", hi, 32'hFFFF_FFFF);

    // 4: mthi then mtlo on consecutive edges
    start = 1'b1;
    md_op = 3'd5;
    A     = 32'h1234_5678;
    @(negedge clk);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'hFFFF_FFFD);
    check("mthi_busy", 32'(busy), 32'd0);
    md_op = 3'd6;
    A     = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    check("mtlo_lo", lo, 32'h9ABC_DEF0);
    check("mtlo_hi", hi, 32'h1234_5678);
    check("mtlo_busy", 32'(busy), 32'd0);

    // Reserved op 7 is a no-op
    start_op(3'd7, 32'hCAFE_F00D, 32'd1);
    check("op7_busy", 32'(busy), 32'd0);
    check("op7_hi", hi, 32'h1234_5678);
    check("op7_lo", lo, 32'h9ABC_DEF0);

    // Signed divide overflow special case
    start_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_busy_cycles", 32'(n), 32'd10);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    // 5: divu 100/7 with a start pulse in busy cycle 4
    start_op(3'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1;
    md_op = 3'd5;
    A     = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    wait_idle(n);
    check("divu_rest_cycles", 32'(n), 32'd6);
    check("divu_hi", hi, 32'd2);
    check("divu_lo", lo, 32'd14);
    check("illegal_start_seen", 32'(illegal_starts), 32'd1);

    // 6: reset in busy cycle 3 of a div, then mult 6*7
    start_op(3'd3, 32'd1000, 32'd3);
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 32'd0);
    start_op(3'd1, 32'd6, 32'd7);
    wait_idle(n);
    check("mult2_busy_cycles", 32'(n), 32'd5);
    check("mult2_lo", lo, 32'd42);
    check("mult2_hi", hi, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
